// File: rtl/bp_hidden_delta_engine.sv
// Hidden-neuron back-prop engine: serial sum of delta*weight, leaky-ReLU derivative, streamed weight gradients.
// Optional bias gradient enabled by defining BP_HIDDEN_BIAS_TERM_EN.
module bp_hidden_delta_engine #(
    parameter int          DATA_WIDTH       = 32,
    parameter int          NUM_FORWARD_NODE = 3,
    parameter int          NUM_INPUT_POINT  = 4,
    parameter logic [31:0] ALPHA            = 32'h3DCCCCCD,
    parameter int          CNT_WIDTH        = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data_node,
    input  logic                  i_fwd_valid,
    input  logic [DATA_WIDTH-1:0] i_fwd_delta,
    input  logic [DATA_WIDTH-1:0] i_fwd_weight,
    output logic                  o_fwd_ready,
    input  logic                  i_point_valid,
    input  logic [DATA_WIDTH-1:0] i_data_point,
    output logic                  o_point_ready,
    output logic [DATA_WIDTH-1:0] o_delta,
    output logic                  o_delta_valid,
    output logic [DATA_WIDTH-1:0] o_error,
    output logic                  o_error_valid,
    output logic                  o_error_last,
    output logic                  o_busy
);
    localparam int          LAT     = 7;
    localparam logic [31:0] FP_ONE  = 32'h3F800000;
    localparam logic [31:0] FP_QNAN = 32'h7FC00000;
`ifdef BP_HIDDEN_BIAS_TERM_EN
    localparam int NUM_GRAD = NUM_INPUT_POINT + 1;
`else
    localparam int NUM_GRAD = NUM_INPUT_POINT;
`endif
    localparam logic [CNT_WIDTH-1:0] FWD_LAST  = CNT_WIDTH'(NUM_FORWARD_NODE - 1);
    localparam logic [CNT_WIDTH-1:0] PT_LAST   = CNT_WIDTH'(NUM_INPUT_POINT - 1);
    localparam logic [CNT_WIDTH-1:0] GRAD_LAST = CNT_WIDTH'(NUM_GRAD - 1);

    // fp32 multiply, round-to-nearest-even; subnormal inputs and results flush to signed zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic               sr;
        logic [7:0]         ea, eb;
        logic [22:0]        ma, mb;
        logic [47:0]        prod;
        logic [23:0]        mant;
        logic               guard, sticky;
        logic [24:0]        rnd;
        logic signed [10:0] ex;
        logic [31:0]        res;
        sr = a[31] ^ b[31];
        ea = a[30:23]; eb = b[30:23];
        ma = a[22:0];  mb = b[22:0];
        res = 32'h0;
        if ((ea == 8'hFF && ma != 23'h0) || (eb == 8'hFF && mb != 23'h0) ||
            (ea == 8'hFF && eb == 8'h00) || (eb == 8'hFF && ea == 8'h00)) begin
            res = FP_QNAN;
        end else if (ea == 8'hFF || eb == 8'hFF) begin
            res = {sr, 8'hFF, 23'h0};
        end else if (ea == 8'h00 || eb == 8'h00) begin
            res = {sr, 31'h0};
        end else begin
            prod = {24'h0, 1'b1, ma} * {24'h0, 1'b1, mb};
            ex   = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127;
            if (prod[47]) begin
                mant = prod[47:24]; guard = prod[23]; sticky = |prod[22:0];
                ex   = ex + 11'sd1;
            end else begin
                mant = prod[46:23]; guard = prod[22]; sticky = |prod[21:0];
            end
            rnd = {1'b0, mant} + {24'h0, guard & (sticky | mant[0])};
            if (rnd[24]) begin
                rnd = rnd >> 1;
                ex  = ex + 11'sd1;
            end
            if (ex >= 11'sd255)    res = {sr, 8'hFF, 23'h0};
            else if (ex <= 11'sd0) res = {sr, 31'h0};
            else                   res = {sr, ex[7:0], rnd[22:0]};
        end
        return res;
    endfunction

    // fp32 add with guard/round/sticky, round-to-nearest-even, same flush-to-zero policy.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       x, y, res;
        logic [7:0]        ea, eb, d;
        logic [26:0]       mx, my, yl;
        logic [27:0]       sum;
        logic [24:0]       rnd;
        logic signed [9:0] ex;
        ea = a[30:23]; eb = b[30:23];
        res = 32'h0;
        if ((ea == 8'hFF && a[22:0] != 23'h0) || (eb == 8'hFF && b[22:0] != 23'h0)) begin
            res = FP_QNAN;
        end else if (ea == 8'hFF && eb == 8'hFF) begin
            res = (a[31] != b[31]) ? FP_QNAN : a;
        end else if (ea == 8'hFF) begin
            res = a;
        end else if (eb == 8'hFF) begin
            res = b;
        end else if (ea == 8'h00 && eb == 8'h00) begin
            res = {a[31] & b[31], 31'h0};
        end else if (ea == 8'h00) begin
            res = b;
        end else if (eb == 8'h00) begin
            res = a;
        end else begin
            if (a[30:0] >= b[30:0]) begin x = a; y = b; end
            else                    begin x = b; y = a; end
            d  = x[30:23] - y[30:23];
            mx = {1'b1, x[22:0], 3'b000};
            yl = {1'b1, y[22:0], 3'b000};
            if (d >= 8'd27) begin
                my = 27'd1;
            end else begin
                my = yl >> d;
                if ((yl & ((27'd1 << d) - 27'd1)) != 27'd0) my[0] = 1'b1;
            end
            ex = $signed({2'b00, x[30:23]});
            if (x[31] == y[31]) begin
                sum = {1'b0, mx} + {1'b0, my};
                if (sum[27]) begin
                    sum = {1'b0, sum[27:1]} | {27'd0, sum[0]};
                    ex  = ex + 10'sd1;
                end
            end else begin
                sum = {1'b0, mx} - {1'b0, my};
                for (int i = 0; i < 26; i++) begin
                    if (sum[26] == 1'b0 && sum != 28'd0) begin
                        sum = sum << 1;
                        ex  = ex - 10'sd1;
                    end
                end
            end
            if (sum == 28'd0) begin
                res = 32'h0;
            end else begin
                rnd = {1'b0, sum[26:3]} + {24'h0, sum[2] & (sum[1] | sum[0] | sum[3])};
                if (rnd[24]) begin
                    rnd = rnd >> 1;
                    ex  = ex + 10'sd1;
                end
                if (ex >= 10'sd255)    res = {x[31], 8'hFF, 23'h0};
                else if (ex <= 10'sd0) res = {x[31], 31'h0};
                else                   res = {x[31], ex[7:0], rnd[22:0]};
            end
        end
        return res;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE, S_FWD, S_MUL_WAIT, S_ADD_WAIT, S_DERIV, S_POINT, S_DRAIN
    } state_t;

    state_t                 state_reg;
    logic [31:0]            z_reg, acc_reg, delta_reg, err_reg;
    logic [CNT_WIDTH-1:0]   fwd_cnt_reg, pt_cnt_reg, emit_cnt_reg;
    logic                   fwd_ready_reg, point_ready_reg, delta_valid_reg;
    logic                   err_valid_reg, err_last_reg, busy_reg;
`ifdef BP_HIDDEN_BIAS_TERM_EN
    logic                   bias_pend_reg;
`endif

    logic                   mul_issue, add_issue;
    logic [31:0]            mul_a, mul_b, add_a, add_b;
    logic [31:0]            mul_pipe_reg [LAT];
    logic [31:0]            add_pipe_reg [LAT];
    logic [LAT-1:0]         mul_vld_reg, add_vld_reg;
    logic [31:0]            mul_out, add_out;
    logic                   mul_vout, add_vout;
    logic                   z_low_unused;

    assign mul_out  = mul_pipe_reg[LAT-1];
    assign add_out  = add_pipe_reg[LAT-1];
    assign mul_vout = mul_vld_reg[LAT-1];
    assign add_vout = add_vld_reg[LAT-1];
    assign z_low_unused = ^z_reg[30:0];

    // Operand steering for the shared cores. The derivative multiply is issued
    // straight from the final adder result so o_delta lands 8 cycles after the last sum.
    always_comb begin
        mul_issue = 1'b0;
        mul_a     = 32'h0;
        mul_b     = 32'h0;
        add_issue = 1'b0;
        add_a     = 32'h0;
        add_b     = 32'h0;
        case (state_reg)
            S_FWD: if (fwd_ready_reg && i_fwd_valid) begin
                mul_issue = 1'b1; mul_a = i_fwd_delta; mul_b = i_fwd_weight;
            end
            S_MUL_WAIT: if (mul_vout) begin
                add_issue = 1'b1; add_a = mul_out; add_b = acc_reg;
            end
            S_ADD_WAIT: if (add_vout && fwd_cnt_reg == FWD_LAST) begin
                mul_issue = 1'b1; mul_a = add_out; mul_b = z_reg[31] ? ALPHA : FP_ONE;
            end
            S_POINT: if (point_ready_reg && i_point_valid) begin
                mul_issue = 1'b1; mul_a = i_data_point; mul_b = delta_reg;
            end
`ifdef BP_HIDDEN_BIAS_TERM_EN
            S_DRAIN: if (bias_pend_reg) begin
                mul_issue = 1'b1; mul_a = FP_ONE; mul_b = delta_reg;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_vld_reg <= '0;
            add_vld_reg <= '0;
            for (int i = 0; i < LAT; i++) begin
                mul_pipe_reg[i] <= 32'h0;
                add_pipe_reg[i] <= 32'h0;
            end
        end else begin
            mul_vld_reg     <= {mul_vld_reg[LAT-2:0], mul_issue};
            add_vld_reg     <= {add_vld_reg[LAT-2:0], add_issue};
            mul_pipe_reg[0] <= fp_mul(mul_a, mul_b);
            add_pipe_reg[0] <= fp_add(add_a, add_b);
            for (int i = 1; i < LAT; i++) begin
                mul_pipe_reg[i] <= mul_pipe_reg[i-1];
                add_pipe_reg[i] <= add_pipe_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            z_reg           <= 32'h0;
            acc_reg         <= 32'h0;
            delta_reg       <= 32'h0;
            err_reg         <= 32'h0;
            fwd_cnt_reg     <= '0;
            pt_cnt_reg      <= '0;
            emit_cnt_reg    <= '0;
            fwd_ready_reg   <= 1'b0;
            point_ready_reg <= 1'b0;
            delta_valid_reg <= 1'b0;
            err_valid_reg   <= 1'b0;
            err_last_reg    <= 1'b0;
            busy_reg        <= 1'b0;
`ifdef BP_HIDDEN_BIAS_TERM_EN
            bias_pend_reg   <= 1'b0;
`endif
        end else begin
            delta_valid_reg <= 1'b0;
            err_valid_reg   <= 1'b0;
            err_last_reg    <= 1'b0;
            err_reg         <= 32'h0;
            if (mul_vout && (state_reg == S_POINT || state_reg == S_DRAIN)) begin
                err_reg       <= mul_out;
                err_valid_reg <= 1'b1;
                err_last_reg  <= (emit_cnt_reg == GRAD_LAST);
                emit_cnt_reg  <= emit_cnt_reg + 1'b1;
            end
            case (state_reg)
                S_IDLE: if (i_valid) begin
                    z_reg         <= i_data_node;
                    acc_reg       <= 32'h0;
                    delta_reg     <= 32'h0;
                    fwd_cnt_reg   <= '0;
                    pt_cnt_reg    <= '0;
                    emit_cnt_reg  <= '0;
                    fwd_ready_reg <= 1'b1;
                    busy_reg      <= 1'b1;
                    state_reg     <= S_FWD;
                end
                S_FWD: if (fwd_ready_reg && i_fwd_valid) begin
                    fwd_ready_reg <= 1'b0;
                    state_reg     <= S_MUL_WAIT;
                end
                S_MUL_WAIT: if (mul_vout) state_reg <= S_ADD_WAIT;
                S_ADD_WAIT: if (add_vout) begin
                    acc_reg     <= add_out;
                    fwd_cnt_reg <= fwd_cnt_reg + 1'b1;
                    if (fwd_cnt_reg == FWD_LAST) begin
                        state_reg <= S_DERIV;
                    end else begin
                        fwd_ready_reg <= 1'b1;
                        state_reg     <= S_FWD;
                    end
                end
                S_DERIV: if (mul_vout) begin
                    delta_reg       <= mul_out;
                    delta_valid_reg <= 1'b1;
                    state_reg       <= S_POINT;
                end
                S_POINT: begin
                    if (point_ready_reg && i_point_valid) begin
                        pt_cnt_reg <= pt_cnt_reg + 1'b1;
                        if (pt_cnt_reg == PT_LAST) begin
                            point_ready_reg <= 1'b0;
                            state_reg       <= S_DRAIN;
`ifdef BP_HIDDEN_BIAS_TERM_EN
                            bias_pend_reg   <= 1'b1;
`endif
                        end
                    end else begin
                        point_ready_reg <= 1'b1;
                    end
                end
                S_DRAIN: begin
`ifdef BP_HIDDEN_BIAS_TERM_EN
                    bias_pend_reg <= 1'b0;
`endif
                    if (err_last_reg) begin
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign o_fwd_ready   = fwd_ready_reg;
    assign o_point_ready = point_ready_reg;
    assign o_delta       = delta_reg;
    assign o_delta_valid = delta_valid_reg;
    assign o_error       = err_reg;
    assign o_error_valid = err_valid_reg;
    assign o_error_last  = err_last_reg;
    assign o_busy        = busy_reg;
endmodule

// File: tb/tb_bp_hidden_delta_engine.sv
// Directed bench for bp_hidden_delta_engine: values, ordering, timing, busy-start immunity and mid-job reset.
module tb_bp_hidden_delta_engine;
    localparam int NF = 3;
    localparam int NP = 4;
`ifdef BP_HIDDEN_BIAS_TERM_EN
    localparam int NG = NP + 1;
`else
    localparam int NG = NP;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_data_node = 32'h0;
    logic        i_fwd_valid = 1'b0;
    logic [31:0] i_fwd_delta = 32'h0, i_fwd_weight = 32'h0;
    logic        o_fwd_ready;
    logic        i_point_valid = 1'b0;
    logic [31:0] i_data_point = 32'h0;
    logic        o_point_ready;
    logic [31:0] o_delta, o_error;
    logic        o_delta_valid, o_error_valid, o_error_last, o_busy;

    bp_hidden_delta_engine dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_data_node(i_data_node),
        .i_fwd_valid(i_fwd_valid), .i_fwd_delta(i_fwd_delta), .i_fwd_weight(i_fwd_weight),
        .o_fwd_ready(o_fwd_ready),
        .i_point_valid(i_point_valid), .i_data_point(i_data_point), .o_point_ready(o_point_ready),
        .o_delta(o_delta), .o_delta_valid(o_delta_valid),
        .o_error(o_error), .o_error_valid(o_error_valid), .o_error_last(o_error_last),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Output monitor: only appends, the stimulus side remembers base indices per job.
    logic [31:0] gq[$];
    logic        lq[$];
    int          gc[$];
    int          dpulse = 0;
    int          bad_idle = 0;
    logic [31:0] dval = 32'h0;
    int          dcyc = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_error_valid) begin
                gq.push_back(o_error);
                lq.push_back(o_error_last);
                gc.push_back(cyc);
            end else if (o_error != 32'h0 || o_error_last) begin
                bad_idle++;
            end
            if (o_delta_valid) begin
                dpulse++;
                dval = o_delta;
                dcyc = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] pd[NF] = '{32'h3F800000, 32'h40000000, 32'h3F000000};
    logic [31:0] pw[NF] = '{32'h3F000000, 32'h3E800000, 32'h40000000};
    logic [31:0] pt[NP] = '{32'h3F800000, 32'hC0400000, 32'h3F000000, 32'h40800000};
    int          pair_gap[NF] = '{0, 20, 7};
    int          pt_gap[NP]   = '{3, 0, 5, 1};
    logic [31:0] exp_delta;
    logic [31:0] exp_g[NG];

    task automatic run_job(input logic [31:0] z, input bit gapped, input bit inject, input bit abort);
        int pair_acc[NF];
        int pt_acc[NP];
        int c0, w, gap, g0, d0, b0, busy_low;
        g0 = gq.size(); d0 = dpulse; b0 = bad_idle;
        i_valid = 1'b1; i_data_node = z; c0 = cyc;
        @(negedge clk);
        i_valid = 1'b0;
        for (int k = 0; k < NF; k++) begin
            gap = gapped ? pair_gap[k] : 0;
            if (gap > 0) begin
                i_fwd_valid = 1'b0;
                if (inject && k == 1) begin
                    i_valid = 1'b1; i_data_node = 32'h3FC00000;
                    @(negedge clk);
                    i_valid = 1'b0; gap--;
                end
                repeat (gap) @(negedge clk);
            end
            i_fwd_valid = 1'b1; i_fwd_delta = pd[k]; i_fwd_weight = pw[k];
            w = 0;
            while (!o_fwd_ready && w < 100) begin @(negedge clk); w++; end
            check($sformatf("fwd_ready_%0d", k), o_fwd_ready, 1'b1);
            pair_acc[k] = cyc;
            if (k > 0) begin
                if (gap == 0) check($sformatf("pair_spacing_%0d", k), pair_acc[k] - pair_acc[k-1], 15);
                else check($sformatf("pair_spacing_min_%0d", k), (pair_acc[k] - pair_acc[k-1]) >= 15, 1);
            end
            @(negedge clk);
        end
        i_fwd_valid = 1'b0;
        for (int j = 0; j < NP; j++) begin
            if (abort && j == 1) begin
                rst_n = 1'b0; i_point_valid = 1'b0;
                #1;
                check("abort_busy", o_busy, 1'b0);
                check("abort_point_ready", o_point_ready, 1'b0);
                check("abort_delta", o_delta, 32'h0);
                check("abort_err_valid", {o_error_valid, o_error_last, o_delta_valid}, 3'b000);
                @(negedge clk); @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            gap = gapped ? pt_gap[j] : 0;
            if (gap > 0) begin
                i_point_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            i_point_valid = 1'b1; i_data_point = pt[j];
            w = 0;
            while (!o_point_ready && w < 200) begin @(negedge clk); w++; end
            check($sformatf("point_ready_%0d", j), o_point_ready, 1'b1);
            pt_acc[j] = cyc;
            @(negedge clk);
        end
        i_point_valid = 1'b0;
        w = 0;
        while (o_busy && w < 200) begin @(negedge clk); w++; end
        busy_low = cyc;
        check("delta", dval, exp_delta);
        check("delta_pulses", dpulse - d0, 1);
        check("delta_cycle", dcyc, pair_acc[NF-1] + 22);
        check("grad_count", gq.size() - g0, NG);
        check("idle_outputs", bad_idle - b0, 0);
        for (int j = 0; j < NG; j++) begin
            check($sformatf("grad_%0d", j), gq[g0+j], exp_g[j]);
            check($sformatf("grad_last_%0d", j), lq[g0+j], (j == NG - 1));
            if (j < NP) check($sformatf("grad_cycle_%0d", j), gc[g0+j], pt_acc[j] + 8);
            else        check("bias_grad_cycle", gc[g0+j], pt_acc[NP-1] + 9);
        end
        check("idle_cycle", busy_low, pt_acc[NP-1] + 9 + (NG - NP));
        if (!gapped) check("job_latency", busy_low - c0, 15 * NF + 17 + NP + (NG - NP));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", o_busy, 1'b0);
        check("rst_ready", {o_fwd_ready, o_point_ready}, 2'b00);
        check("rst_delta", o_delta, 32'h0);
        check("rst_error", o_error, 32'h0);
        check("rst_flags", {o_delta_valid, o_error_valid, o_error_last}, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);

        // Job A: z=1.5, positive slope
        exp_delta = 32'h40000000;
        exp_g[0] = 32'h40000000; exp_g[1] = 32'hC0C00000;
        exp_g[2] = 32'h3F800000; exp_g[3] = 32'h41000000;
`ifdef BP_HIDDEN_BIAS_TERM_EN
        exp_g[NG-1] = exp_delta;
`endif
        run_job(32'h3FC00000, 1'b0, 1'b0, 1'b0);

        // Job B: z=-1.5, alpha slope
        exp_delta = 32'h3E4CCCCD;
        exp_g[0] = 32'h3E4CCCCD; exp_g[1] = 32'hBF19999A;
        exp_g[2] = 32'h3DCCCCCD; exp_g[3] = 32'h3F4CCCCD;
`ifdef BP_HIDDEN_BIAS_TERM_EN
        exp_g[NG-1] = exp_delta;
`endif
        run_job(32'hBFC00000, 1'b0, 1'b0, 1'b0);

        // Job C: z=-0.0, gapped traffic, stray start pulse while busy
        run_job(32'h80000000, 1'b1, 1'b1, 1'b0);

        // Job D: reset during POINT, then a clean job A
        run_job(32'h3FC00000, 1'b0, 1'b0, 1'b1);
        exp_delta = 32'h40000000;
        exp_g[0] = 32'h40000000; exp_g[1] = 32'hC0C00000;
        exp_g[2] = 32'h3F800000; exp_g[3] = 32'h41000000;
`ifdef BP_HIDDEN_BIAS_TERM_EN
        exp_g[NG-1] = exp_delta;
`endif
        run_job(32'h3FC00000, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
        $fatal(1);
    end
endmodule

// File: doc/bp_hidden_delta_engine.md
# bp_hidden_delta_engine

Parametrised back-propagation engine for one hidden-layer neuron in the DQN training datapath. It serially accumulates the weighted sum of forward-layer deltas, Σ δ_k·w_k, using one shared fp32 multiplier and one shared fp32 adder. It applies the leaky-ReLU derivative of the neuron's stored pre-activation to produce the neuron delta. It then streams per-input weight gradients (delta × previous-layer activation) to the weight-update stage.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; fixed to IEEE-754 single by the fp32 cores.
- NUM_FORWARD_NODE, 3, number of (delta, weight) pairs accumulated; ≥1.
- NUM_INPUT_POINT, 4, number of previous-layer activations streamed for gradients; ≥1.
- ALPHA, 32'h3DCCCCCD, leaky-ReLU negative slope (0.1).
- CNT_WIDTH, 8, width of the pair/point counters; must hold max(NUM_FORWARD_NODE, NUM_INPUT_POINT)+1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- i_valid  in  1  start pulse; sampled in IDLE only.
- i_data_node  in  32  neuron pre-activation z, captured with i_valid.
- i_fwd_valid  in  1  forward pair valid.
- i_fwd_delta  in  32  forward-node delta δ_k.
- i_fwd_weight  in  32  weight w_k connecting this neuron to node k.
- o_fwd_ready  out  1  pair accept; a transfer occurs when valid&ready.
- i_point_valid  in  1  activation valid.
- i_data_point  in  32  previous-layer activation a_j.
- o_point_ready  out  1  activation accept.
- o_delta  out  32  neuron delta; held from o_delta_valid until next start.
- o_delta_valid  out  1  single-cycle pulse.
- o_error  out  32  gradient a_j·delta; 0 when not valid.
- o_error_valid  out  1  gradient valid.
- o_error_last  out  1  with final gradient of the job.
- o_busy  out  1  high outside IDLE.

## Operation
- FSM states: IDLE, FWD, MUL_WAIT, ADD_WAIT, DERIV, POINT, DRAIN.
- IDLE: on i_valid, capture z and clear accumulator to +0.0 (32'h0) and the counters. Go to FWD. i_valid outside IDLE is ignored.
- FWD: o_fwd_ready=1. On transfer, issue δ_k·w_k to the multiplier and go to MUL_WAIT.
- MUL_WAIT: on multiplier valid_out, issue product+acc to the adder and go to ADD_WAIT.
- ADD_WAIT: on adder valid_out, write acc and increment the pair count. Go to FWD while count<NUM_FORWARD_NODE, else go to DERIV.
- Summation order is strictly k=0..N-1: acc=((0+p0)+p1)+…, which makes the result bit-exact and reproducible.
- DERIV: issue acc·(z[31] ? ALPHA : 32'h3F800000). Note that −0.0 selects ALPHA. On result, register o_delta, pulse o_delta_valid, and go to POINT.
- POINT: o_point_ready=1. Each transfer issues a_j·delta to the pipelined multiplier, one per cycle allowed. After NUM_INPUT_POINT transfers, ready drops and the FSM enters DRAIN.
- DRAIN: wait for all outstanding products. o_error_last accompanies the final gradient, then the FSM returns to IDLE.
- Gradients emerge in acceptance order. No output backpressure exists; the consumer must always accept.
- Reset values: all outputs 0; state IDLE; acc, z, delta 0.
- Reset mid-job: the job is aborted immediately and all in-flight core results are discarded. The cores' valid pipelines are also reset.
- NaN/Inf propagate per the fp32 core behaviour; the block does no special handling.

## Timing
- fp32 multiplier and adder: 7-cycle latency each, fully pipelined.
- Pair accepted at cycle t: product at t+7, adder issued t+7, sum at t+14, o_fwd_ready high again at t+15. Minimum 15 cycles per pair.
- Last sum at cycle S: o_delta_valid at S+8 (7-cycle multiply + register). o_point_ready rises at S+9.
- Point accepted at cycle p: o_error_valid at p+8.
- With back-to-back points, the job finishes at last accept+8 and the FSM is in IDLE the next cycle. o_busy falls in the same cycle.
- Minimum job latency, no stalls: 1 + 15·NUM_FORWARD_NODE + 8 + NUM_INPUT_POINT + 8 cycles.

## Configuration
- BP_HIDDEN_BIAS_TERM_EN defined: after NUM_INPUT_POINT external points, the block internally injects one extra point of 1.0 (32'h3F800000) without using o_point_ready. This yields NUM_INPUT_POINT+1 gradients, and the last one equals delta and carries o_error_last.
- Undefined: exactly NUM_INPUT_POINT gradients, with no bias gradient.

## Test plan
- z=1.5; pairs (1.0,0.5),(2.0,0.25),(0.5,2.0) → o_delta=32'h40000000. Points 1.0,−3.0,0.5,4.0 → o_error 40000000, C0C00000, 3F800000, 41000000, with last on the 4th.
- Same pairs, z=−1.5 → o_delta=32'h3E4CCCCD (0.2); z=32'h80000000 also selects ALPHA.
- i_fwd_valid gapped 0–20 cycles between pairs and i_point_valid gapped randomly → identical values and order; o_fwd_ready holds the 15-cycle spacing.
- i_valid asserted while busy, mid-FWD → ignored; result unchanged.
- rst_n low during POINT → all outputs 0 next edge; a fresh job after release gives correct results with no stale o_error_valid.
- BP_HIDDEN_BIAS_TERM_EN defined, first vector → 5th gradient 32'h40000000 with o_error_last; only 4 point transfers occur.
